// File: rtl/reg_file_bank_if.sv
// Register-file bank bus: request signals from the master, read data,
// error status and the register 0..3 views back from the slave.
interface reg_file_bank_if #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 4
);
    logic             WrEn;
    logic             RdEn;
    logic [ADDR-1:0]  Address;
    logic [WIDTH-1:0] WrData;
    logic [WIDTH-1:0] WrMask;
    logic [WIDTH-1:0] RdData;
    logic             RdData_VLD;
    logic             Err;
    logic [7:0]       ErrCnt;
    logic [WIDTH-1:0] REG0;
    logic [WIDTH-1:0] REG1;
    logic [WIDTH-1:0] REG2;
    logic [WIDTH-1:0] REG3;

    modport master (
        output WrEn, RdEn, Address, WrData, WrMask,
        input  RdData, RdData_VLD, Err, ErrCnt, REG0, REG1, REG2, REG3
    );

    modport slave (
        input  WrEn, RdEn, Address, WrData, WrMask,
        output RdData, RdData_VLD, Err, ErrCnt, REG0, REG1, REG2, REG3
    );
endinterface

// File: rtl/reg_file_bank.sv
// Parameterised register bank with masked writes, a pipelined read path,
// a lock bit protecting registers 0..3 and a saturating error counter.
module reg_file_bank #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 16,
    parameter int               ADDR      = 4,
    parameter int               RD_LAT    = 1,
    parameter int               LOCK_ADDR = DEPTH - 1,
    parameter logic [WIDTH-1:0] RST_REG2  = 'h81,
    parameter logic [WIDTH-1:0] RST_REG3  = 'h20
) (
    input logic            CLK,
    input logic            RST,
    reg_file_bank_if.slave bus
);
    localparam logic [ADDR-1:0] LOCK_IDX = ADDR'(LOCK_ADDR);
    localparam int              LAST     = RD_LAT - 1;

    logic [WIDTH-1:0] regs [DEPTH];

    logic             in_range;
    logic             low_addr;
    logic             locked;
    logic             blocked;
    logic             collide;
    logic             wr_only;
    logic             rd_only;
    logic             wr_accept;
    logic             wr_err;
    logic             err_next;
    logic [WIDTH-1:0] rd_value;

    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_oob;
    logic [WIDTH-1:0]  pipe_data [RD_LAT];

    // When the bank fills the whole address space every index is legal.
    generate
        if (DEPTH >= (2 ** ADDR)) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_part_range
            assign in_range = (bus.Address < ADDR'(DEPTH));
        end
    endgenerate

    assign low_addr  = (bus.Address < ADDR'(4));
    assign locked    = regs[LOCK_ADDR][0];
    assign blocked   = locked && low_addr && (bus.Address != LOCK_IDX);
    assign collide   = bus.WrEn && bus.RdEn;
    assign wr_only   = bus.WrEn && !bus.RdEn;
    assign rd_only   = bus.RdEn && !bus.WrEn;
    assign wr_accept = wr_only && in_range && !blocked;
    assign wr_err    = wr_only && (!in_range || blocked);
    assign rd_value  = in_range ? regs[bus.Address] : '0;
    assign err_next  = collide || wr_err || (pipe_vld[LAST] && pipe_oob[LAST]);

    assign bus.REG0 = regs[0];
    assign bus.REG1 = regs[1];
    assign bus.REG2 = regs[2];
    assign bus.REG3 = regs[3];

    // Register storage: reset image, then bit-masked writes to accepted addresses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (i == 2) ? RST_REG2 : (i == 3) ? RST_REG3 : '0;
            end
        end else if (wr_accept) begin
            regs[bus.Address] <= (regs[bus.Address] & ~bus.WrMask) | (bus.WrData & bus.WrMask);
        end
    end

    // Read pipeline: stage 0 captures at the accept edge, later stages only delay.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pipe_vld <= '0;
            pipe_oob <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= rd_only;
            pipe_oob[0]  <= rd_only && !in_range;
            pipe_data[0] <= rd_value;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_oob[i]  <= pipe_oob[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    // Output stage: read data is held between reads, Err and ErrCnt move together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.RdData     <= '0;
            bus.RdData_VLD <= 1'b0;
            bus.Err        <= 1'b0;
            bus.ErrCnt     <= 8'd0;
        end else begin
            bus.RdData_VLD <= pipe_vld[LAST];
            if (pipe_vld[LAST]) begin
                bus.RdData <= pipe_data[LAST];
            end
            bus.Err <= err_next;
            if (err_next && (bus.ErrCnt != 8'hFF)) begin
                bus.ErrCnt <= bus.ErrCnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_reg_file_bank.sv
// Directed bench for reg_file_bank: a vector table of single requests plus
// hand-written pipeline, lock, saturation, reset-in-flight and range sequences.
module tb_reg_file_bank;
    localparam int LAT = 2;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] mask;
        logic       exp_vld;
        logic [7:0] exp_rdata;
        int         exp_err;
        logic [7:0] exp_errcnt;
        logic [7:0] exp_reg1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vec_count  = 0;
    int miss_count = 0;

    int         mon_err;
    int         mon_vld;
    int         mon_vld_at;

    vec_t vecs [18];

    reg_file_bank_if #(.WIDTH(8), .ADDR(4)) bus ();
    reg_file_bank_if #(.WIDTH(8), .ADDR(4)) bus_s ();

    reg_file_bank #(.RD_LAT(LAT)) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    reg_file_bank #(.DEPTH(12), .RD_LAT(1)) u_dut_small (
        .CLK (clk),
        .RST (rst),
        .bus (bus_s)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic driveIdle();
        bus.WrEn = 1'b0;
        bus.RdEn = 1'b0;
        bus.Address = 4'd0;
        bus.WrData = 8'd0;
        bus.WrMask = 8'd0;
        bus_s.WrEn = 1'b0;
        bus_s.RdEn = 1'b0;
        bus_s.Address = 4'd0;
        bus_s.WrData = 8'd0;
        bus_s.WrMask = 8'd0;
    endtask

    // One request for one cycle, then watch LAT+1 samples for Err and VLD.
    task automatic applyStimulus(input vec_t v);
        bus.WrEn    = v.wr;
        bus.RdEn    = v.rd;
        bus.Address = v.addr;
        bus.WrData  = v.data;
        bus.WrMask  = v.mask;
        stepClock();
        driveIdle();
        mon_err    = 0;
        mon_vld    = 0;
        mon_vld_at = -1;
        for (int k = 0; k <= LAT; k++) begin
            if (k > 0) stepClock();
            if (bus.Err === 1'b1) mon_err++;
            if (bus.RdData_VLD === 1'b1) begin
                mon_vld++;
                mon_vld_at = k;
            end
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 4'd0,  8'h00, 8'h00, 1'b1, 8'h00, 0, 8'd0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 4'd1,  8'h00, 8'h00, 1'b1, 8'h00, 0, 8'd0, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 4'd2,  8'h00, 8'h00, 1'b1, 8'h81, 0, 8'd0, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 4'd3,  8'h00, 8'h00, 1'b1, 8'h20, 0, 8'd0, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 4'd5,  8'hFF, 8'hFF, 1'b0, 8'h20, 0, 8'd0, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, 4'd5,  8'h00, 8'h0F, 1'b0, 8'h20, 0, 8'd0, 8'h00};
        vecs[6]  = '{1'b0, 1'b1, 4'd5,  8'h00, 8'h00, 1'b1, 8'hF0, 0, 8'd0, 8'h00};
        vecs[7]  = '{1'b1, 1'b0, 4'd15, 8'h01, 8'hFF, 1'b0, 8'hF0, 0, 8'd0, 8'h00};
        vecs[8]  = '{1'b1, 1'b0, 4'd1,  8'hAA, 8'hFF, 1'b0, 8'hF0, 1, 8'd1, 8'h00};
        vecs[9]  = '{1'b0, 1'b1, 4'd1,  8'h00, 8'h00, 1'b1, 8'h00, 0, 8'd1, 8'h00};
        vecs[10] = '{1'b1, 1'b0, 4'd15, 8'h00, 8'hFF, 1'b0, 8'h00, 0, 8'd1, 8'h00};
        vecs[11] = '{1'b1, 1'b0, 4'd1,  8'hAA, 8'hFF, 1'b0, 8'h00, 0, 8'd1, 8'hAA};
        vecs[12] = '{1'b0, 1'b1, 4'd1,  8'h00, 8'h00, 1'b1, 8'hAA, 0, 8'd1, 8'hAA};
        vecs[13] = '{1'b1, 1'b0, 4'd4,  8'h33, 8'hFF, 1'b0, 8'hAA, 0, 8'd1, 8'hAA};
        vecs[14] = '{1'b1, 1'b1, 4'd4,  8'h55, 8'hFF, 1'b0, 8'hAA, 1, 8'd2, 8'hAA};
        vecs[15] = '{1'b0, 1'b1, 4'd4,  8'h00, 8'h00, 1'b1, 8'h33, 0, 8'd2, 8'hAA};
        vecs[16] = '{1'b1, 1'b0, 4'd6,  8'hA5, 8'h3C, 1'b0, 8'h33, 0, 8'd2, 8'hAA};
        vecs[17] = '{1'b0, 1'b1, 4'd6,  8'h00, 8'h00, 1'b1, 8'h24, 0, 8'd2, 8'hAA};

        driveIdle();

        // Reset values while RST is held.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rddata", 32'(bus.RdData), 32'h00);
        checkOutput("rst_vld", 32'(bus.RdData_VLD), 32'h0);
        checkOutput("rst_err", 32'(bus.Err), 32'h0);
        checkOutput("rst_errcnt", 32'(bus.ErrCnt), 32'h00);
        checkOutput("rst_reg0", 32'(bus.REG0), 32'h00);
        checkOutput("rst_reg2", 32'(bus.REG2), 32'h81);
        checkOutput("rst_reg3", 32'(bus.REG3), 32'h20);
        rst = 1'b0;

        // Vector table: reset readback, masked write, lock, collision.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_vld", i), 32'(mon_vld), 32'(vecs[i].exp_vld));
            if (vecs[i].exp_vld) begin
                checkOutput($sformatf("vec%0d_vld_at", i), 32'(mon_vld_at), 32'(LAT));
            end
            checkOutput($sformatf("vec%0d_rddata", i), 32'(bus.RdData), 32'(vecs[i].exp_rdata));
            checkOutput($sformatf("vec%0d_err", i), 32'(mon_err), 32'(vecs[i].exp_err));
            checkOutput($sformatf("vec%0d_errcnt", i), 32'(bus.ErrCnt), 32'(vecs[i].exp_errcnt));
            checkOutput($sformatf("vec%0d_reg1", i), 32'(bus.REG1), 32'(vecs[i].exp_reg1));
        end

        // Read on the cycle right after a write returns the new value.
        bus.WrEn = 1'b1; bus.Address = 4'd7; bus.WrData = 8'h3C; bus.WrMask = 8'hFF;
        stepClock();
        bus.WrEn = 1'b0; bus.RdEn = 1'b1;
        stepClock();
        driveIdle();
        repeat (LAT - 1) stepClock();
        checkOutput("raw_pre_vld", 32'(bus.RdData_VLD), 32'h0);
        stepClock();
        checkOutput("raw_vld", 32'(bus.RdData_VLD), 32'h1);
        checkOutput("raw_rddata", 32'(bus.RdData), 32'h3C);

        // Back-to-back reads of 2, 3, 0 give three consecutive VLD cycles in order.
        for (int k = 1; k <= 6; k++) begin
            if (k == 1) begin bus.RdEn = 1'b1; bus.Address = 4'd2; end
            else if (k == 2) bus.Address = 4'd3;
            else if (k == 3) bus.Address = 4'd0;
            else driveIdle();
            if (k <= 3) stepClock();
            else begin
                driveIdle();
                stepClock();
            end
            if (k == 3) driveIdle();
            checkOutput($sformatf("pipe_vld_k%0d", k), 32'(bus.RdData_VLD),
                        32'((k - LAT >= 1) && (k - LAT <= 3)));
            if (k - LAT == 1) checkOutput("pipe_data0", 32'(bus.RdData), 32'h81);
            if (k - LAT == 2) checkOutput("pipe_data1", 32'(bus.RdData), 32'h20);
            if (k - LAT == 3) checkOutput("pipe_data2", 32'(bus.RdData), 32'h00);
        end

        // Small bank (DEPTH=12, RD_LAT=1): in-range read, out-of-range read and write.
        bus_s.RdEn = 1'b1; bus_s.Address = 4'd2;
        stepClock();
        driveIdle();
        checkOutput("s_rd2_early_vld", 32'(bus_s.RdData_VLD), 32'h0);
        stepClock();
        checkOutput("s_rd2_vld", 32'(bus_s.RdData_VLD), 32'h1);
        checkOutput("s_rd2_data", 32'(bus_s.RdData), 32'h81);
        checkOutput("s_rd2_err", 32'(bus_s.Err), 32'h0);
        bus_s.RdEn = 1'b1; bus_s.Address = 4'd14;
        stepClock();
        driveIdle();
        checkOutput("s_oobrd_early_err", 32'(bus_s.Err), 32'h0);
        stepClock();
        checkOutput("s_oobrd_vld", 32'(bus_s.RdData_VLD), 32'h1);
        checkOutput("s_oobrd_data", 32'(bus_s.RdData), 32'h00);
        checkOutput("s_oobrd_err", 32'(bus_s.Err), 32'h1);
        checkOutput("s_oobrd_errcnt", 32'(bus_s.ErrCnt), 32'd1);
        bus_s.WrEn = 1'b1; bus_s.Address = 4'd13; bus_s.WrData = 8'h77; bus_s.WrMask = 8'hFF;
        stepClock();
        driveIdle();
        checkOutput("s_oobwr_err", 32'(bus_s.Err), 32'h1);
        checkOutput("s_oobwr_errcnt", 32'(bus_s.ErrCnt), 32'd2);
        stepClock();
        checkOutput("s_oobwr_err_clear", 32'(bus_s.Err), 32'h0);

        // 300 collisions saturate ErrCnt at 255.
        bus.WrEn = 1'b1; bus.RdEn = 1'b1; bus.Address = 4'd4; bus.WrData = 8'h55; bus.WrMask = 8'hFF;
        repeat (300) stepClock();
        driveIdle();
        checkOutput("sat_err", 32'(bus.Err), 32'h1);
        checkOutput("sat_errcnt", 32'(bus.ErrCnt), 32'd255);
        stepClock();
        checkOutput("sat_err_clear", 32'(bus.Err), 32'h0);
        checkOutput("sat_errcnt_hold", 32'(bus.ErrCnt), 32'd255);

        // Reset while a read is in flight: no VLD afterwards, counters cleared.
        bus.RdEn = 1'b1; bus.Address = 4'd2;
        stepClock();
        driveIdle();
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst_vld", 32'(bus.RdData_VLD), 32'h0);
        checkOutput("midrst_errcnt", 32'(bus.ErrCnt), 32'd0);
        checkOutput("midrst_rddata", 32'(bus.RdData), 32'h00);
        checkOutput("midrst_reg1", 32'(bus.REG1), 32'h00);
        repeat (2) stepClock();
        rst = 1'b0;
        mon_vld = 0;
        for (int k = 0; k < LAT + 2; k++) begin
            stepClock();
            if (bus.RdData_VLD === 1'b1) mon_vld++;
        end
        checkOutput("postrst_no_vld", 32'(mon_vld), 32'd0);
        checkOutput("postrst_errcnt", 32'(bus.ErrCnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end
endmodule

// File: doc/reg_file_bank.md
REG_FILE_BANK -- requirements
Module: reg_file_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: register width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: number of registers, 4..2^ADDR.
REQ-003 SHALL have parameter ADDR, default 4: address width.
REQ-004 SHALL have parameter RD_LAT, default 1: read latency in cycles, legal values 1 or 2.
REQ-005 SHALL have parameter LOCK_ADDR, default DEPTH-1: address of the lock register.
REQ-006 SHALL have parameters RST_REG2, default 'h81, and RST_REG3, default 'h20: reset values of registers 2 and 3.
REQ-007 SHALL have one clock and an asynchronous, active-high reset.
REQ-008 CLK  in  1  clock; all state updates on its rising edge.
REQ-009 RST  in  1  asynchronous, active-high reset.
REQ-010 WrEn  in  1  write request.
REQ-011 RdEn  in  1  read request.
REQ-012 Address  in  ADDR  register index.
REQ-013 WrData  in  WIDTH  write data.
REQ-014 WrMask  in  WIDTH  per-bit write enable; 1 = bit updated.
REQ-015 RdData  out  WIDTH  read data, held between reads.
REQ-016 RdData_VLD  out  1  one-cycle read-valid pulse.
REQ-017 Err  out  1  one-cycle error pulse.
REQ-018 ErrCnt  out  8  saturating error count.
REQ-019 REG0, REG1, REG2, REG3  out  WIDTH each  continuous view of registers 0..3.

Function
REQ-020 A write SHALL be accepted when WrEn=1, RdEn=0, Address<DEPTH and the write is not blocked by REQ-023.
- On the next edge, reg[A] <= (reg[A] & ~WrMask) | (WrData & WrMask).
REQ-021 A read SHALL be accepted when RdEn=1, WrEn=0 and Address<DEPTH.
- reg[A] is captured at the accept edge.
- RdData updates and RdData_VLD pulses high exactly RD_LAT cycles after the accept edge.
REQ-022 Reads SHALL be fully pipelined: back-to-back reads produce back-to-back VLD pulses in order.
REQ-023 Lock: when bit 0 of reg[LOCK_ADDR] is 1, writes to addresses 0..3 SHALL be ignored and SHALL raise Err.
- LOCK_ADDR itself stays writable at all times.
REQ-024 WrEn=1 and RdEn=1 in the same cycle: no write and no read SHALL occur; Err SHALL pulse on the next cycle.
REQ-025 Read with Address>=DEPTH: RdData SHALL be 0 with the normal VLD timing, and Err SHALL pulse in the VLD cycle.
REQ-026 Write with Address>=DEPTH: the write SHALL be ignored and Err SHALL pulse on the next cycle.
REQ-027 A read accepted the cycle after a write to the same address SHALL return the newly written value.
REQ-028 ErrCnt SHALL increment by 1 per Err pulse and saturate at 255, with no wrap.
REQ-029 Idle cycles (WrEn=0, RdEn=0) SHALL leave all registers and RdData unchanged, with VLD=0 and Err=0.
REQ-030 REG0..REG3 SHALL reflect register contents combinationally, with no added latency.

Reset
REQ-031 While RST=1, and immediately on its assertion:
- all registers SHALL be 0, except reg[2]=RST_REG2 and reg[3]=RST_REG3;
- RdData=0, RdData_VLD=0, Err=0, ErrCnt=0;
- the read pipeline SHALL be flushed.
REQ-032 A read in flight when RST asserts SHALL produce no VLD pulse after reset releases.
REQ-033 The first request SHALL be accepted on the first rising CLK edge with RST=0.

Verification
REQ-034 Reset check: release reset, read addresses 0..3 -> RdData 0x00, 0x00, 0x81, 0x20; REG2=0x81; ErrCnt=0.
REQ-035 Masked write: write 0xFF to address 5 with mask 0xFF, then 0x00 with mask 0x0F, then read 5 -> RdData=0xF0 with VLD RD_LAT cycles after the accept edge.
REQ-036 Lock: write 0x01 to address 15, then 0xAA to address 1 -> Err pulse, REG1 stays 0x00, ErrCnt=1; write 0x00 to address 15, repeat the write -> REG1=0xAA.
REQ-037 Collision: WrEn=RdEn=1 at address 4 with data 0x55 -> register 4 unchanged, no VLD, one Err pulse.
REQ-038 Pipeline (RD_LAT=2): reads of addresses 2, 3, 0 on consecutive cycles -> VLD high for 3 cycles starting 2 cycles after the first accept, RdData 0x81, 0x20, 0x00.
REQ-039 Saturation and reset mid-read: 300 collisions -> ErrCnt=255; then a read followed by RST asserted before VLD -> no VLD pulse, ErrCnt=0.
